digit_sprite_renderer: RTL and testbench
========================================

DIGIT_SPRITE_RENDERER -- requirements
Module: digit_sprite_renderer

Interface
REQ-001 Parameter SPRITE_SIZE, default 32, sprite edge length in pixels.
REQ-002 Parameter TRANSPARENT, default 12'hFFF, ROM color treated as see-through.
REQ-003 clk  input  1  system/pixel clock; the only clock.
REQ-004 reset_n  input  1  reset, asynchronous, active-low.
REQ-005 x  input  10  current pixel column from the VGA sync generator.
REQ-006 y  input  10  current pixel row from the VGA sync generator.
REQ-007 video_on  input  1  high in the visible region.
REQ-008 frame_tick  input  1  one-cycle pulse at frame start.
REQ-009 pos_x_in, pos_y_in  input  10 each  requested sprite top-left corner.
REQ-010 pos_valid  input  1  position request valid.
REQ-011 pos_ready  output  1  block can accept a position request.
REQ-012 blink_en  input  1  enables 32-frame-on / 32-frame-off blinking.
REQ-013 bg_rgb  input  12  background color.
REQ-014 rom_row, rom_col  output  5 each  address to the digit ROM; the ROM registers these internally.
REQ-015 rom_data  input  12  ROM color, valid one clk after the address.
REQ-016 rgb_out  output  12  registered pixel color to the DAC.

Function
REQ-017 Stage 0 (combinational): hit = video_on and x in [pos_x, pos_x+SPRITE_SIZE) and y in [pos_y, pos_y+SPRITE_SIZE). Compute the comparisons in 11 bits so that pos+32 > 1023 does not wrap.
REQ-018 rom_row = (y - pos_y)[4:0] and rom_col = (x - pos_x)[4:0]. Both are driven every cycle. They are don't-care when hit = 0.
REQ-019 Stage 1 register: hit_d, video_on_d, visible_d (blink gating), bg_d. These align with rom_data.
REQ-020 Stage 2: rgb_out is registered.
  - 0 if !video_on_d.
  - rom_data if hit_d and visible_d and rom_data != TRANSPARENT.
  - bg_d otherwise.
REQ-021 Latency from x/y/video_on to rgb_out is exactly 2 clk cycles, with no bubbles. A new pixel is accepted every clk.
REQ-022 Position handshake: a request is accepted when pos_valid && pos_ready. The accepted value goes into the pending register, pending_full is set, and pos_ready drops the next cycle.
REQ-023 On frame_tick with pending_full set: the active position is loaded from pending, pending_full is cleared, and pos_ready rises the next cycle.
REQ-024 On frame_tick with no pending request, the active position is unchanged.
REQ-025 Simultaneous accept and frame_tick: the frame_tick applies the previously pending state (none). The new request is held and applied at the next frame_tick.
REQ-026 The active position never changes except on frame_tick, so there is no mid-frame tearing.
REQ-027 Blink counter: 6 bits, incremented on each frame_tick, wraps 63 -> 0.
REQ-028 Visibility: visible = !blink_en || !cnt[5]. Blink_en changes take effect on the next pixel.

Reset
REQ-029 While reset_n = 0, asynchronously:
  - rgb_out = 0
  - pos_ready = 1
  - pending_full = 0
  - active position = (0,0)
  - blink counter = 0
  - all pipeline registers = 0
REQ-030 Reset asserted mid-frame or mid-handshake discards any pending request. Operation resumes on the first clk after deassertion.

Structure
REQ-031 The shared package holds SPRITE_SIZE, TRANSPARENT, COLOR_W=12, COORD_W=10 and the color typedef.
REQ-032 The digit ROM is instantiated by the parent, not inside this block. The position handshake and blink logic stay inline; no sub-module.

Verification
REQ-033 Reset, then pos (100,50) accepted and frame_tick. Scan x=100..131, y=50, with ROM returning 12'h000 -> rgb_out = 12'h000 two cycles after each pixel; x=99 and x=132 -> bg_rgb.
REQ-034 ROM returns 12'hFFF inside the sprite with bg_rgb = 12'h00F -> rgb_out = 12'h00F; video_on = 0 -> rgb_out = 0.
REQ-035 Request (200,200) mid-frame -> pos_ready = 0. Sprite is still drawn at the old position until frame_tick, then at (200,200), and pos_ready = 1.
REQ-036 pos_valid and frame_tick in the same cycle with nothing pending -> position unchanged this frame; new position applied at the next frame_tick.
REQ-037 blink_en = 1 for 64 frame_ticks -> sprite visible for frames 0-31, background for frames 32-63, then visible again after the wrap.
REQ-038 pos (1000,470): x = 1010 -> rom_col = 10 and hit; x = 5 -> no hit (no 10-bit wrap).

Source files
------------

// File: rtl/digit_sprite_renderer_pkg.sv
// Shared types and constants for the digit sprite renderer.
package digit_sprite_renderer_pkg;

    localparam int unsigned SPRITE_SIZE = 32;
    localparam int unsigned COLOR_W     = 12;
    localparam int unsigned COORD_W     = 10;
    localparam int unsigned ROM_ADDR_W  = 5;
    localparam int unsigned BLINK_W     = 6;

    typedef logic [COLOR_W-1:0]    color_t;
    typedef logic [COORD_W-1:0]    coord_t;
    typedef logic [ROM_ADDR_W-1:0] rom_addr_t;
    typedef logic [BLINK_W-1:0]    blink_cnt_t;

    localparam color_t TRANSPARENT = 12'hFFF;

    // Sprite top-left corner.
    typedef struct packed {
        coord_t x;
        coord_t y;
    } pos_t;

    // True when v lies in [base, base+size). One extra bit keeps base+size
    // from wrapping when the sprite hangs off the right/bottom edge.
    function automatic logic in_span(input coord_t v, input coord_t base,
                                     input logic [COORD_W:0] size);
        logic [COORD_W:0] v_ext;
        logic [COORD_W:0] lo;
        logic [COORD_W:0] hi;
        v_ext = {1'b0, v};
        lo    = {1'b0, base};
        hi    = lo + size;
        return (v_ext >= lo) && (v_ext < hi);
    endfunction

endpackage

// File: rtl/digit_sprite_renderer.sv
// Overlays a digit sprite, fetched from an external registered ROM, onto the
// background colour. Sprite position is updated only at frame start through a
// one-deep pending register; the sprite can blink with a 64-frame period.
module digit_sprite_renderer
    import digit_sprite_renderer_pkg::*;
#(
    parameter int unsigned SPRITE_SIZE = digit_sprite_renderer_pkg::SPRITE_SIZE,
    parameter color_t      TRANSPARENT = digit_sprite_renderer_pkg::TRANSPARENT
) (
    input  logic      clk,
    input  logic      reset_n,
    input  coord_t    x,
    input  coord_t    y,
    input  logic      video_on,
    input  logic      frame_tick,
    input  coord_t    pos_x_in,
    input  coord_t    pos_y_in,
    input  logic      pos_valid,
    output logic      pos_ready,
    input  logic      blink_en,
    input  color_t    bg_rgb,
    output rom_addr_t rom_row,
    output rom_addr_t rom_col,
    input  color_t    rom_data,
    output color_t    rgb_out
);

    localparam logic [COORD_W:0] SPRITE_EXT = (COORD_W+1)'(SPRITE_SIZE);

    // Position handshake and blink state
    pos_t       act_q, act_d;
    pos_t       pend_q, pend_d;
    logic       pend_full_q, pend_full_d;
    blink_cnt_t blink_cnt_q, blink_cnt_d;
    logic       accept;

    // Pipeline
    logic       hit_s0;
    logic       visible_s0;
    logic       hit_q;
    logic       video_on_q;
    logic       visible_q;
    color_t     bg_q;
    color_t     rgb_q, rgb_d;

    assign pos_ready = ~pend_full_q;
    assign accept    = pos_valid & ~pend_full_q;

    // Next state for the active/pending position and the blink counter.
    // An accept can only happen with the pending slot empty, while a frame
    // tick only consumes a full slot, so the two never fight over it; a
    // request arriving on a tick waits for the following tick.
    always_comb begin
        act_d       = act_q;
        pend_d      = pend_q;
        pend_full_d = pend_full_q;
        blink_cnt_d = blink_cnt_q;
        if (frame_tick) begin
            blink_cnt_d = blink_cnt_q + 6'd1;
            if (pend_full_q) begin
                act_d       = pend_q;
                pend_full_d = 1'b0;
            end
        end
        if (accept) begin
            pend_d      = '{x: pos_x_in, y: pos_y_in};
            pend_full_d = 1'b1;
        end
    end

    // Control registers; reset drops any request in flight.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            act_q       <= '0;
            pend_q      <= '0;
            pend_full_q <= 1'b0;
            blink_cnt_q <= '0;
        end else begin
            act_q       <= act_d;
            pend_q      <= pend_d;
            pend_full_q <= pend_full_d;
            blink_cnt_q <= blink_cnt_d;
        end
    end

    // ---- Stage 0: hit test and ROM address (combinational) ----
    assign hit_s0     = video_on
                        & in_span(x, act_q.x, SPRITE_EXT)
                        & in_span(y, act_q.y, SPRITE_EXT);
    assign visible_s0 = ~blink_en | ~blink_cnt_q[BLINK_W-1];

    // Only the low bits of the offset address the ROM, so a 5-bit subtract
    // gives the same result as the full-width difference.
    assign rom_row = y[ROM_ADDR_W-1:0] - act_q.y[ROM_ADDR_W-1:0];
    assign rom_col = x[ROM_ADDR_W-1:0] - act_q.x[ROM_ADDR_W-1:0];

    // ---- Stage 1: side-band registers aligned with rom_data ----
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            hit_q      <= 1'b0;
            video_on_q <= 1'b0;
            visible_q  <= 1'b0;
            bg_q       <= '0;
        end else begin
            hit_q      <= hit_s0;
            video_on_q <= video_on;
            visible_q  <= visible_s0;
            bg_q       <= bg_rgb;
        end
    end

    // ---- Stage 2: colour select ----
    always_comb begin
        rgb_d = bg_q;
        if (!video_on_q) begin
            rgb_d = '0;
        end else if (hit_q && visible_q && (rom_data != TRANSPARENT)) begin
            rgb_d = rom_data;
        end
    end

    // Registered output to the DAC.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rgb_q <= '0;
        end else begin
            rgb_q <= rgb_d;
        end
    end

    assign rgb_out = rgb_q;

endmodule

// File: tb/tb_digit_sprite_renderer.sv
// Directed bench for digit_sprite_renderer with a frame-level reference model.
module tb_digit_sprite_renderer;
    import digit_sprite_renderer_pkg::*;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [9:0]  x, y;
    logic        video_on, frame_tick;
    logic [9:0]  pos_x_in, pos_y_in;
    logic        pos_valid;
    logic        pos_ready;
    logic        blink_en;
    logic [11:0] bg_rgb;
    logic [4:0]  rom_row, rom_col;
    logic [11:0] rom_data = 12'h000;
    logic [11:0] rgb_out;
    int          rom_mode;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    digit_sprite_renderer dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .x         (x),
        .y         (y),
        .video_on  (video_on),
        .frame_tick(frame_tick),
        .pos_x_in  (pos_x_in),
        .pos_y_in  (pos_y_in),
        .pos_valid (pos_valid),
        .pos_ready (pos_ready),
        .blink_en  (blink_en),
        .bg_rgb    (bg_rgb),
        .rom_row   (rom_row),
        .rom_col   (rom_col),
        .rom_data  (rom_data),
        .rgb_out   (rgb_out)
    );

    // ROM contents selectable per test.
    function automatic logic [11:0] rom_fn(input int mode, input int row, input int col);
        logic [4:0] r5, c5;
        r5 = 5'(row);
        c5 = 5'(col);
        case (mode)
            0:       return 12'h000;
            1:       return 12'hFFF;
            2:       return {2'b01, r5, c5};
            default: return (col < 16) ? 12'hFFF : {2'b10, r5, c5};
        endcase
    endfunction

    // Registered ROM: data one clock after the address.
    always @(posedge clk) rom_data <= rom_fn(rom_mode, int'(rom_row), int'(rom_col));

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    int          m_ax, m_ay, m_px, m_py, m_cnt;
    bit          m_pend;
    logic [11:0] pipe1, pipe2;
    bit          v1 = 1'b0, v2 = 1'b0;

    function automatic bit model_hit();
        int xi, yi;
        xi = int'(x);
        yi = int'(y);
        return video_on && xi >= m_ax && xi < m_ax + 32 && yi >= m_ay && yi < m_ay + 32;
    endfunction

    function automatic logic [11:0] model_pixel();
        logic [11:0] c;
        int row, col;
        if (!video_on) return 12'h000;
        row = (int'(y) - m_ay) & 31;
        col = (int'(x) - m_ax) & 31;
        c = rom_fn(rom_mode, row, col);
        if (model_hit() && (!blink_en || m_cnt < 32) && c != 12'hFFF) return c;
        return bg_rgb;
    endfunction

    initial begin
        bit acc;
        logic [11:0] e;
        forever begin
            @(posedge clk);
            if (!reset_n) begin
                m_ax = 0; m_ay = 0; m_px = 0; m_py = 0; m_cnt = 0; m_pend = 1'b0;
                pipe1 = 12'h000; pipe2 = 12'h000; v1 = 1'b1; v2 = 1'b1;
            end else begin
                e = model_pixel();
                pipe2 = pipe1; v2 = v1;
                pipe1 = e;     v1 = 1'b1;
                acc = pos_valid && !m_pend;
                if (frame_tick) begin
                    if (m_pend) begin
                        m_ax = m_px; m_ay = m_py; m_pend = 1'b0;
                    end
                    m_cnt = (m_cnt + 1) % 64;
                end
                if (acc) begin
                    m_pend = 1'b1; m_px = int'(pos_x_in); m_py = int'(pos_y_in);
                end
            end
        end
    end

    // Compare process: every cycle out of reset.
    initial begin
        forever begin
            @(negedge clk);
            if (reset_n) begin
                if (v2) check("rgb_out_model", 32'(rgb_out), 32'(pipe2));
                check("pos_ready_model", 32'(pos_ready), 32'(!m_pend));
                if (model_hit()) begin
                    check("rom_row_model", 32'(rom_row), 32'((int'(y) - m_ay) & 31));
                    check("rom_col_model", 32'(rom_col), 32'((int'(x) - m_ax) & 31));
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic request(input int px, input int py);
        pos_x_in = 10'(px); pos_y_in = 10'(py); pos_valid = 1'b1;
        tick();
        pos_valid = 1'b0;
    endtask

    task automatic ftick();
        frame_tick = 1'b1;
        tick();
        frame_tick = 1'b0;
    endtask

    task automatic pix_check(input string name, input int px, input int py,
                             input logic von, input logic [11:0] exp);
        x = 10'(px); y = 10'(py); video_on = von;
        tick();
        tick();
        check(name, 32'(rgb_out), 32'(exp));
    endtask

    initial begin
        reset_n = 1'b0; x = 10'd3; y = 10'd4; video_on = 1'b0; frame_tick = 1'b0;
        pos_x_in = '0; pos_y_in = '0; pos_valid = 1'b0; blink_en = 1'b0;
        bg_rgb = 12'h000; rom_mode = 0;
        tick(); tick();
        check("reset_rgb", 32'(rgb_out), 32'h000);
        check("reset_ready", 32'(pos_ready), 32'd1);
        check("reset_rom_col", 32'(rom_col), 32'd3);
        check("reset_rom_row", 32'(rom_row), 32'd4);
        reset_n = 1'b1;
        tick();

        // Sprite at (100,50), scan a row across it.
        bg_rgb = 12'h0A5;
        request(100, 50);
        ftick();
        video_on = 1'b1; y = 10'd50;
        for (int xx = 99; xx <= 133; xx++) begin
            x = 10'(xx);
            tick();
            if (xx >= 100)
                check("scan_row", 32'(rgb_out),
                      32'(((xx - 1) >= 100 && (xx - 1) <= 131) ? 12'h000 : 12'h0A5));
        end

        // Transparent ROM colour and blanking.
        rom_mode = 1; bg_rgb = 12'h00F;
        pix_check("transparent", 110, 50, 1'b1, 12'h00F);
        pix_check("blank", 110, 50, 1'b0, 12'h000);

        // Patterned ROM: addresses checked by the model across edges.
        rom_mode = 2; bg_rgb = 12'h0A5; video_on = 1'b1;
        for (int yy = 49; yy <= 82; yy += 11) begin
            y = 10'(yy);
            for (int xx = 95; xx <= 140; xx++) begin
                x = 10'(xx);
                tick();
            end
        end
        pix_check("pattern_3_5", 105, 53, 1'b1, 12'h465);

        // Mid-frame request holds until frame_tick.
        rom_mode = 0; bg_rgb = 12'h00F;
        request(200, 200);
        check("req_ready_low", 32'(pos_ready), 32'd0);
        pix_check("old_pos_drawn", 100, 50, 1'b1, 12'h000);
        pix_check("new_pos_not_yet", 200, 200, 1'b1, 12'h00F);
        ftick();
        check("ready_after_tick", 32'(pos_ready), 32'd1);
        pix_check("new_pos_drawn", 200, 200, 1'b1, 12'h000);
        pix_check("old_pos_gone", 100, 50, 1'b1, 12'h00F);

        // Request coinciding with frame_tick and nothing pending.
        pos_x_in = 10'd300; pos_y_in = 10'd100; pos_valid = 1'b1; frame_tick = 1'b1;
        tick();
        pos_valid = 1'b0; frame_tick = 1'b0;
        check("simul_ready_low", 32'(pos_ready), 32'd0);
        pix_check("simul_not_moved", 300, 100, 1'b1, 12'h00F);
        pix_check("simul_still_old", 200, 200, 1'b1, 12'h000);
        ftick();
        pix_check("simul_moved", 300, 100, 1'b1, 12'h000);
        check("simul_ready_high", 32'(pos_ready), 32'd1);

        // Sprite near the right edge: no 10-bit wrap.
        request(1000, 470);
        ftick();
        rom_mode = 2; bg_rgb = 12'h0A5;
        x = 10'd1010; y = 10'd475; video_on = 1'b1;
        #1;
        check("edge_rom_col", 32'(rom_col), 32'd10);
        check("edge_rom_row", 32'(rom_row), 32'd5);
        tick(); tick();
        check("edge_hit", 32'(rgb_out), 32'h4AA);
        pix_check("edge_no_wrap", 5, 475, 1'b1, 12'h0A5);
        pix_check("edge_corner", 1023, 501, 1'b1, 12'h7F7);
        pix_check("edge_below", 1023, 502, 1'b1, 12'h0A5);

        // Reset during a pending request.
        rom_mode = 0; x = 10'd5; y = 10'd5;
        request(400, 300);
        check("pend_ready_low", 32'(pos_ready), 32'd0);
        tick();
        reset_n = 1'b0;
        #1;
        check("async_reset_rgb", 32'(rgb_out), 32'h000);
        check("async_reset_ready", 32'(pos_ready), 32'd1);
        tick(); tick();
        reset_n = 1'b1;
        tick();
        ftick();
        pix_check("pend_discarded", 400, 300, 1'b1, 12'h0A5);
        pix_check("pos_reset_origin", 5, 5, 1'b1, 12'h000);

        // Blinking over a full counter wrap (counter now 1).
        rom_mode = 0; bg_rgb = 12'h00F;
        request(100, 50);
        ftick();
        blink_en = 1'b1;
        for (int f = 2; f <= 66; f++) begin
            pix_check("blink", 110, 55, 1'b1, ((f % 64) < 32) ? 12'h000 : 12'h00F);
            if (f == 40) begin
                blink_en = 1'b0;
                pix_check("blink_disabled", 110, 55, 1'b1, 12'h000);
                blink_en = 1'b1;
            end
            ftick();
        end

        video_on = 1'b0;
        tick(); tick(); tick();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
